// File: rtl/hack_mul_seq_pkg.sv
// rtl/hack_mul_seq_pkg.sv - shared FSM state encoding and ALU control constant for hack_mul_seq
package hack_mul_seq_pkg;

  // Sequencer states (2-bit encoding)
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DBL  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Hack ALU controls {zx,nx,zy,ny,f,no} selecting x+y
  localparam logic [5:0] ALU_CTRL_ADD = 6'b000010;

endpackage

// File: rtl/hack_mul_seq_halu.sv
// rtl/hack_mul_seq_halu.sv - Hack ALU (zx/nx/zy/ny/f/no) shared by the multiply sequencer
module hack_mul_seq_halu #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             zx,
  input  logic             nx,
  input  logic             zy,
  input  logic             ny,
  input  logic             f,
  input  logic             no,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] x_z, x_n, y_z, y_n, res;

  // Standard Hack ALU: optional zero/negate on each input, add or and, optional output negate
  always_comb begin
    x_z = zx ? '0 : x;
    x_n = nx ? ~x_z : x_z;
    y_z = zy ? '0 : y;
    y_n = ny ? ~y_z : y_z;
    res = f ? (x_n + y_n) : (x_n & y_n);
    out = no ? ~res : res;
  end

endmodule

// File: rtl/hack_mul_seq.sv
// rtl/hack_mul_seq.sv - multi-cycle shift-and-add 16-bit multiplier on a shared Hack ALU (option: HACK_MUL_EARLY_EXIT_EN)
module hack_mul_seq
  import hack_mul_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] prod,
  output logic             prod_zr,
  output logic             prod_ng
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] acc, acc_nxt;
  logic [WIDTH-1:0] mcand, mcand_nxt;
  logic [WIDTH-1:0] mplier, mplier_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] alu_x;
  logic [WIDTH-1:0] alu_out;

  // ALU x operand: accumulator while adding, multiplicand while doubling
  always_comb begin
    alu_x = (state == S_ADD) ? acc : mcand;
  end

  hack_mul_seq_halu #(.WIDTH(WIDTH)) u_halu (
    .x   (alu_x),
    .y   (mcand),
    .zx  (ALU_CTRL_ADD[5]),
    .nx  (ALU_CTRL_ADD[4]),
    .zy  (ALU_CTRL_ADD[3]),
    .ny  (ALU_CTRL_ADD[2]),
    .f   (ALU_CTRL_ADD[1]),
    .no  (ALU_CTRL_ADD[0]),
    .out (alu_out)
  );

  // Next-state and datapath update selection
  always_comb begin
    state_nxt  = state;
    acc_nxt    = acc;
    mcand_nxt  = mcand;
    mplier_nxt = mplier;
    cnt_nxt    = cnt;
    case (state)
      S_IDLE: begin
        if (start) begin
          acc_nxt    = '0;
          mcand_nxt  = a;
          mplier_nxt = b;
          cnt_nxt    = '0;
          state_nxt  = b[0] ? S_ADD : S_DBL;
`ifdef HACK_MUL_EARLY_EXIT_EN
          if (b == '0) state_nxt = S_DONE;
`endif
        end
      end
      S_ADD: begin
        acc_nxt   = alu_out;
        state_nxt = S_DBL;
      end
      S_DBL: begin
        mcand_nxt  = alu_out;
        mplier_nxt = mplier >> 1;
        cnt_nxt    = cnt + CNT_W'(1);
        if (cnt == CNT_LAST) state_nxt = S_DONE;
        else                 state_nxt = mplier[1] ? S_ADD : S_DBL;
`ifdef HACK_MUL_EARLY_EXIT_EN
        // No multiplier bits left: remaining steps could only double mcand
        if (mplier_nxt == '0) state_nxt = S_DONE;
`endif
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else begin
      state  <= state_nxt;
      acc    <= acc_nxt;
      mcand  <= mcand_nxt;
      mplier <= mplier_nxt;
      cnt    <= cnt_nxt;
    end
  end

  // Status and result outputs decoded from state and accumulator
  always_comb begin
    busy    = (state == S_ADD) || (state == S_DBL);
    done    = (state == S_DONE);
    prod    = acc;
    prod_zr = (acc == '0);
    prod_ng = acc[WIDTH-1];
  end

endmodule

// File: tb/tb_hack_mul_seq.sv
// tb/tb_hack_mul_seq.sv - self-checking bench for hack_mul_seq against an arithmetic reference model
module tb_hack_mul_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        busy, done, prod_zr, prod_ng;
  logic [15:0] prod;

  int compared = 0;
  int mismatched = 0;

  hack_mul_seq #(.WIDTH(16), .CNT_W(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .prod    (prod),
    .prod_zr (prod_zr),
    .prod_ng (prod_ng)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Edges from the start edge (counted as 1) until done is visible
  function automatic int exp_latency(input logic [15:0] mb);
    int pc;
    int msb;
    pc = $countones(mb);
`ifdef HACK_MUL_EARLY_EXIT_EN
    if (mb == 16'd0) return 1;
    msb = 0;
    for (int i = 0; i < 16; i++) if (mb[i]) msb = i;
    return msb + 1 + pc + 1;
`else
    msb = 0;
    return 16 + pc + 1 + msb;
`endif
  endfunction

  task automatic run_mul(input logic [15:0] ta, input logic [15:0] tb_v, input int inj, input string tag);
    logic [15:0] ep;
    int el;
    int edges;
    ep = 16'((32'(ta) * 32'(tb_v)) & 32'hFFFF);
    el = exp_latency(tb_v);
    a = ta;
    b = tb_v;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    edges = 1;
    chk({tag, " busy_after_start"}, 32'(busy), 32'(el > 1));
    while (done !== 1'b1 && edges < 64) begin
      if (inj != 0 && edges == inj - 1) begin
        start = 1'b1; a = 16'd9; b = 16'd9;
      end else if (inj != 0 && edges == inj) begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      edges++;
    end
    start = 1'b0;
    chk({tag, " done"}, 32'(done), 32'd1);
    chk({tag, " latency"}, 32'(edges), 32'(el));
    chk({tag, " prod"}, 32'(prod), 32'(ep));
    chk({tag, " zr"}, 32'(prod_zr), 32'(ep == 16'd0));
    chk({tag, " ng"}, 32'(prod_ng), 32'(ep[15]));
    @(posedge clk); #1;
    chk({tag, " done_one_cycle"}, 32'(done), 32'd0);
    chk({tag, " idle_busy"}, 32'(busy), 32'd0);
    chk({tag, " prod_held"}, 32'(prod), 32'(ep));
  endtask

  initial begin
    #1;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset prod", 32'(prod), 32'd0);
    chk("reset zr", 32'(prod_zr), 32'd1);
    chk("reset ng", 32'(prod_ng), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_mul(16'd3, 16'd5, 0, "t1");
    run_mul(16'hFFFF, 16'hFFFF, 0, "t2");
    run_mul(16'd7, 16'hFFFF, 0, "t3");
    run_mul(16'd1234, 16'd0, 0, "t4");

    run_mul(16'd3, 16'd5, 4, "t5");
    repeat (3) begin
      @(posedge clk); #1;
      chk("t5 no_second_done", 32'(done), 32'd0);
      chk("t5 no_second_busy", 32'(busy), 32'd0);
    end

    a = 16'd3; b = 16'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6 rst busy", 32'(busy), 32'd0);
    chk("t6 rst done", 32'(done), 32'd0);
    chk("t6 rst prod", 32'(prod), 32'd0);
    chk("t6 rst zr", 32'(prod_zr), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_mul(16'd2, 16'd3, 0, "t6");

    run_mul(16'h8000, 16'd1, 0, "msb_x1");
    run_mul(16'h0001, 16'h8000, 0, "x_b15");
    run_mul(16'h0000, 16'hA5A5, 0, "zero_a");
    for (int i = 0; i < 20; i++) begin
      run_mul(16'($urandom), 16'($urandom), 0, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
